// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one step per clock).
// Optional macro BCD_CHECK_EN: reject input digits > 9 with a one-cycle err result.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BW = 4 * DIGITS;
  localparam int TW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [BW-1:0]    r_bcd;
  logic [BW-1:0]    w_bcd_nx;
  logic [BIN_W-1:0] r_bin;
  logic [BIN_W-1:0] w_bin_nx;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic             r_busy;
  logic             w_busy_nx;
  logic             r_done;
  logic             w_done_nx;
  logic [BIN_W-1:0] r_out;
  logic [BIN_W-1:0] w_out_nx;
  logic             r_err;
  logic             w_err_nx;
  logic             r_bad;
  logic             w_bad_nx;
  logic             w_in_bad;
  logic [TW-1:0]    w_shift;
  logic [BW-1:0]    w_adj;

`ifdef BCD_CHECK_EN
  always_comb begin
    w_in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) w_in_bad = 1'b1;
    end
  end
`else
  assign w_in_bad = 1'b0;
`endif

  assign w_shift = {r_bcd, r_bin} >> 1;

  // digits of 8 or more were 5+ before the halving step
  always_comb begin
    w_adj = w_shift[TW-1:BIN_W];
    for (int i = 0; i < DIGITS; i++) begin
      if (w_adj[4*i +: 4] >= 4'd8) begin
        w_adj[4*i +: 4] = w_adj[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_bcd_nx   = r_bcd;
    w_bin_nx   = r_bin;
    w_cnt_nx   = r_cnt;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_out_nx   = r_out;
    w_err_nx   = r_err;
    w_bad_nx   = r_bad;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_bcd_nx   = bcd_in;
          w_bin_nx   = '0;
          w_cnt_nx   = '0;
          w_busy_nx  = 1'b1;
          w_bad_nx   = w_in_bad;
          w_state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (r_bad) begin
          w_done_nx  = 1'b1;
          w_err_nx   = 1'b1;
          w_busy_nx  = 1'b0;
          w_bad_nx   = 1'b0;
          w_state_nx = IDLE;
        end else begin
          w_bcd_nx = w_adj;
          w_bin_nx = w_shift[BIN_W-1:0];
          w_cnt_nx = r_cnt + 1'b1;
          if (r_cnt == CW'(BIN_W - 1)) begin
            w_out_nx   = w_shift[BIN_W-1:0];
            w_done_nx  = 1'b1;
            w_err_nx   = 1'b0;
            w_busy_nx  = 1'b0;
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd  <= '0;
      r_bin  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_out  <= '0;
      r_err  <= 1'b0;
      r_bad  <= 1'b0;
    end else begin
      r_bcd  <= w_bcd_nx;
      r_bin  <= w_bin_nx;
      r_cnt  <= w_cnt_nx;
      r_busy <= w_busy_nx;
      r_done <= w_done_nx;
      r_out  <= w_out_nx;
      r_err  <= w_err_nx;
      r_bad  <= w_bad_nx;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bin_out = r_out;
  assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: transaction-level model plus directed/random stimulus.
// Honours BCD_CHECK_EN the same way the design does.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int BW     = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [BW-1:0]    bcd_in = '0;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  int n_tot = 0;
  int n_bad = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int dec(input logic [BW-1:0] v);
    int r = 0;
    int m = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r += int'(v[4*i +: 4]) * m;
      m *= 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [BW-1:0] v);
    bit b = 0;
`ifdef BCD_CHECK_EN
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) b = 1;
`endif
    return b;
  endfunction

  // Transaction model: accept when idle, finish after a fixed number of edges.
  bit m_busy = 0, m_done = 0, m_err = 0, m_pbad = 0;
  int m_out = 0, m_pend = 0, m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_out = 0; m_left = 0; m_pbad = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          m_pend = dec(bcd_in);
          m_pbad = has_bad(bcd_in);
          m_left = m_pbad ? 1 : BIN_W;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          if (m_pbad) m_err = 1;
          else begin
            m_out = m_pend;
            m_err = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("bin_out", int'(bin_out), m_out);
      chk("err", int'(err), int'(m_err));
    end
  end

  task automatic pulse(input logic [BW-1:0] v);
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [BW-1:0] v, input int exp_bin, input int lat);
    int n;
    pulse(v);
    wait_done(n);
    chk("latency", n, lat);
    chk("lit_bin", int'(bin_out), exp_bin);
    chk("lit_err", int'(err), 0);
  endtask

  initial begin
    int n, cnt;
    logic [BW-1:0] v;
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(12'h999, 999, BIN_W);
    run(12'h000, 0, BIN_W);

    // start held high: second value accepted right after done
    @(negedge clk);
    bcd_in = 12'h255;
    start  = 1'b1;
    @(negedge clk);
    wait_done(n);
    chk("held_lat1", n, BIN_W);
    chk("held_bin1", int'(bin_out), 'h0FF);
    bcd_in = 12'h128;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("held_lat2", n, BIN_W);
    chk("held_bin2", int'(bin_out), 'h080);

    // re-pulse while busy is ignored
    pulse(12'h500);
    repeat (2) @(negedge clk);
    bcd_in = 12'h111;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(n);
    chk("ign_bin", int'(bin_out), 'h1F4);
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("ign_extra_done", cnt, 0);

    // reset in mid-conversion
    pulse(12'h777);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bin", int'(bin_out), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run(12'h042, 42, BIN_W);

    // invalid digit
    pulse(12'h1A5);
    wait_done(n);
`ifdef BCD_CHECK_EN
    chk("inv_lat", n, 1);
    chk("inv_err", int'(err), 1);
    chk("inv_bin", int'(bin_out), 42);
`else
    chk("inv_lat", n, BIN_W);
    chk("inv_err", int'(err), 0);
`endif
    run(12'h321, 321, BIN_W);

    repeat (40) begin
      bit bd;
      for (int i = 0; i < DIGITS; i++) begin
`ifdef BCD_CHECK_EN
        v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
`else
        v[4*i +: 4] = 4'($urandom_range(0, 9));
`endif
      end
      bd = has_bad(v);
      pulse(v);
      if (!bd && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        bcd_in = BW'($urandom);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
      end
      wait_done(n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
